// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: shared defaults and helpers for the L2 data array slice.
//   L2_NUM_SETS / L2_NUM_WAYS / L2_LINE_BITS : default geometry
//   line_t / be_t                            : line and byte-enable types at default width
//   line_addr()                              : flat line address from {index, way}
package l2_cache_pkg;

  localparam int L2_NUM_SETS  = 32;
  localparam int L2_NUM_WAYS  = 4;
  localparam int L2_LINE_BITS = 512;

  typedef logic [L2_LINE_BITS-1:0]   line_t;
  typedef logic [L2_LINE_BITS/8-1:0] be_t;

  // A direct-mapped array has no way bits in its address, so the way input is
  // dropped rather than doubling the storage.
  function automatic int unsigned line_addr(input int unsigned idx,
                                            input int unsigned way,
                                            input int unsigned num_ways);
    return (num_ways > 1) ? (idx * num_ways + way) : idx;
  endfunction

endpackage

// File: rtl/l2_wb_buffer.sv
// l2_wb_buffer: one-entry valid/ready register slice for a victim line.
//   clk, rst                       : clock, synchronous active-high reset
//   load, load_data/index/way      : capture a new victim (caller honours load_ready)
//   valid, ready                   : handshake toward memory
//   data, index, way               : held victim, stable while valid & !ready
//   load_ready                     : !valid | ready, a load may be taken this cycle
module l2_wb_buffer
  import l2_cache_pkg::*;
#(
  parameter int DATA_W = L2_LINE_BITS,
  parameter int IDX_W  = 5,
  parameter int WAY_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [IDX_W-1:0]  load_index,
  input  logic [WAY_W-1:0]  load_way,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic [IDX_W-1:0]  index,
  output logic [WAY_W-1:0]  way,
  output logic              load_ready
);

  assign load_ready = ~valid | ready;

  // A load in the same cycle as a drain replaces the entry, so valid stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      index <= '0;
      way   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      index <= load_index;
      way   <= load_way;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/l2_data_array_wb.sv
// l2_data_array_wb: set-associative L2 line store with victim writeback buffer.
//   clk, rst                 : clock, synchronous active-high reset
//   index, way               : line address
//   rd_en -> rd_data/rd_valid: registered read, one-cycle latency, rd_perr with it
//   update, wr_data, wr_be   : byte-enabled write-hit merge
//   refill, refill_data      : line fill; evict=1 also pushes the old line to the victim buffer
//   refill_ready             : an evicting refill can be taken this cycle
//   wb_valid/wb_ready, wb_data/wb_index/wb_way : victim handshake toward memory
// Build option: define L2_DATA_PARITY_EN to store one even-parity bit per
// 64-bit word and flag mismatches on reads; otherwise rd_perr is tied low.
module l2_data_array_wb
  import l2_cache_pkg::*;
#(
  parameter int NUM_SETS  = L2_NUM_SETS,
  parameter int NUM_WAYS  = L2_NUM_WAYS,
  parameter int LINE_BITS = L2_LINE_BITS,
  parameter int IDX_W     = $clog2(NUM_SETS),
  parameter int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       index,
  input  logic [WAY_W-1:0]       way,
  input  logic                   rd_en,
  input  logic                   update,
  input  logic [LINE_BITS-1:0]   wr_data,
  input  logic [LINE_BITS/8-1:0] wr_be,
  input  logic                   refill,
  input  logic [LINE_BITS-1:0]   refill_data,
  input  logic                   evict,
  output logic                   refill_ready,
  output logic [LINE_BITS-1:0]   rd_data,
  output logic                   rd_valid,
  output logic                   rd_perr,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [LINE_BITS-1:0]   wb_data,
  output logic [IDX_W-1:0]       wb_index,
  output logic [WAY_W-1:0]       wb_way
);

  localparam int DEPTH  = NUM_SETS * NUM_WAYS;
  localparam int AW     = $clog2(DEPTH);
  localparam int NBYTES = LINE_BITS / 8;

  logic [LINE_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        addr;
  logic [LINE_BITS-1:0] cur_line;
  logic [LINE_BITS-1:0] merged;
  logic                 refill_acc;
  logic                 update_acc;
  logic                 rd_acc;
  logic                 wb_load;

  assign addr     = AW'(line_addr(32'(index), 32'(way), NUM_WAYS));
  assign cur_line = mem[addr];

  // A blocked evicting refill drops out of arbitration entirely, letting a
  // same-cycle update or read proceed.
  assign refill_acc = refill & (~evict | refill_ready);
  assign update_acc = update & ~refill_acc;
  assign rd_acc     = rd_en & ~refill_acc & ~update;
  assign wb_load    = refill_acc & evict;

  always_comb begin
    merged = cur_line;
    for (int b = 0; b < NBYTES; b++) begin
      if (wr_be[b]) merged[b*8 +: 8] = wr_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (refill_acc)      mem[addr] <= refill_data;
      else if (update_acc) mem[addr] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= cur_line;
    end
  end

`ifdef L2_DATA_PARITY_EN
  localparam int NWORDS = LINE_BITS / 64;

  logic [NWORDS-1:0] par_mem [DEPTH];

  function automatic logic [NWORDS-1:0] calc_par(input logic [LINE_BITS-1:0] l);
    logic [NWORDS-1:0] p;
    for (int w = 0; w < NWORDS; w++) p[w] = ^l[w*64 +: 64];
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (refill_acc)      par_mem[addr] <= calc_par(refill_data);
      else if (update_acc) par_mem[addr] <= calc_par(merged);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_perr <= 1'b0;
    else     rd_perr <= rd_acc & (|(par_mem[addr] ^ calc_par(cur_line)));
  end
`else
  assign rd_perr = 1'b0;
`endif

  l2_wb_buffer #(
    .DATA_W (LINE_BITS),
    .IDX_W  (IDX_W),
    .WAY_W  (WAY_W)
  ) u_wb_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (wb_load),
    .load_data  (cur_line),
    .load_index (index),
    .load_way   (way),
    .valid      (wb_valid),
    .ready      (wb_ready),
    .data       (wb_data),
    .index      (wb_index),
    .way        (wb_way),
    .load_ready (refill_ready)
  );

endmodule

// File: tb/tb_l2_data_array_wb.sv
// tb_l2_data_array_wb: directed bench for l2_data_array_wb at default geometry
// (32 sets, 4 ways, 512-bit lines). Expected reads go into a queue when the
// request is driven and are popped when rd_valid appears.
module tb_l2_data_array_wb;
  import l2_cache_pkg::*;

  logic         clk;
  logic         rst;
  logic [4:0]   index;
  logic [1:0]   way;
  logic         rd_en;
  logic         update;
  line_t        wr_data;
  be_t          wr_be;
  logic         refill;
  line_t        refill_data;
  logic         evict;
  logic         refill_ready;
  line_t        rd_data;
  logic         rd_valid;
  logic         rd_perr;
  logic         wb_valid;
  logic         wb_ready;
  line_t        wb_data;
  logic [4:0]   wb_index;
  logic [1:0]   wb_way;

  l2_data_array_wb dut (
    .clk          (clk),
    .rst          (rst),
    .index        (index),
    .way          (way),
    .rd_en        (rd_en),
    .update       (update),
    .wr_data      (wr_data),
    .wr_be        (wr_be),
    .refill       (refill),
    .refill_data  (refill_data),
    .evict        (evict),
    .refill_ready (refill_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_perr      (rd_perr),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_data      (wb_data),
    .wb_index     (wb_index),
    .wb_way       (wb_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    line_t data;
    logic  perr;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  line_t   mdl [128];
  line_t   last_rd;
  int      vectors;
  int      miscompares;

  function automatic line_t mk(input logic [7:0] tag);
    line_t l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = {tag, 24'(w * 3 + 1)};
    return l;
  endfunction

  function automatic line_t merge(input line_t old, input line_t d, input be_t be);
    line_t r;
    r = old;
    for (int b = 0; b < 64; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input line_t obs, input line_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en       = 1'b0;
    update      = 1'b0;
    refill      = 1'b0;
    evict       = 1'b0;
    wr_data     = '0;
    wr_be       = '0;
    refill_data = '0;
  endtask

  task automatic tick(input bit exp_rv);
    rd_exp_t e;
    @(posedge clk);
    #1;
    chk("rd_valid", 512'(rd_valid), 512'(exp_rv));
    if (rd_valid) begin
      chk("rd_q_nonempty", 512'(exp_q.size() != 0), 512'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e.data);
        chk("rd_perr", 512'(rd_perr), 512'(e.perr));
        last_rd = e.data;
      end
    end else if (exp_q.size() != 0) begin
      exp_q.delete(0);
    end
  endtask

  task automatic set_addr(input int i, input int w);
    index = 5'(i);
    way   = 2'(w);
  endtask

  task automatic do_read(input int i, input int w);
    set_addr(i, w);
    rd_en = 1'b1;
    exp_q.push_back('{data: mdl[i*4+w], perr: 1'b0});
    tick(1);
    idle();
  endtask

  task automatic do_refill(input int i, input int w, input line_t d);
    set_addr(i, w);
    refill      = 1'b1;
    refill_data = d;
    mdl[i*4+w]  = d;
    tick(0);
    idle();
  endtask

  task automatic do_update(input int i, input int w, input line_t d, input be_t be);
    set_addr(i, w);
    update     = 1'b1;
    wr_data    = d;
    wr_be      = be;
    mdl[i*4+w] = merge(mdl[i*4+w], d, be);
    tick(0);
    idle();
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    line_t a_mod;
    vectors     = 0;
    miscompares = 0;
    last_rd     = '0;
    rst         = 1'b1;
    wb_ready    = 1'b0;
    set_addr(0, 0);
    idle();
    tick(0);
    tick(0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_rd_perr", 512'(rd_perr), 512'(0));
    chk("rst_wb_valid", 512'(wb_valid), 512'(0));
    chk("rst_wb_data", wb_data, '0);
    chk("rst_wb_index", 512'(wb_index), 512'(0));
    chk("rst_wb_way", 512'(wb_way), 512'(0));
    chk("rst_refill_ready", 512'(refill_ready), 512'(1));
    rst = 1'b0;

    // Plain refill and read back
    do_refill(5, 2, mk(8'hA0));
    chk("no_evict_wb_valid", 512'(wb_valid), 512'(0));
    do_read(5, 2);
    tick(0);
    chk("rd_data_hold", rd_data, last_rd);

    // Byte-0 update
    do_update(5, 2, {64{8'hFF}}, 64'h1);
    a_mod = mdl[5*4+2];
    do_read(5, 2);

    do_refill(7, 1, mk(8'hC0));

    // Evicting refill with memory stalled
    set_addr(5, 2);
    refill      = 1'b1;
    evict       = 1'b1;
    refill_data = mk(8'hB0);
    #1;
    chk("evict_refill_ready", 512'(refill_ready), 512'(1));
    mdl[5*4+2] = mk(8'hB0);
    tick(0);
    idle();
    chk("wb_valid_load", 512'(wb_valid), 512'(1));
    chk("wb_data_load", wb_data, a_mod);
    chk("wb_index_load", 512'(wb_index), 512'(5));
    chk("wb_way_load", 512'(wb_way), 512'(2));
    do_read(5, 2);

    // Blocked evicting refill; same-cycle read still served
    set_addr(7, 1);
    refill      = 1'b1;
    evict       = 1'b1;
    refill_data = mk(8'hD0);
    rd_en       = 1'b1;
    #1;
    chk("blocked_refill_ready", 512'(refill_ready), 512'(0));
    exp_q.push_back('{data: mdl[7*4+1], perr: 1'b0});
    tick(1);
    chk("stall_wb_valid", 512'(wb_valid), 512'(1));
    chk("stall_wb_data", wb_data, a_mod);
    chk("stall_wb_index", 512'(wb_index), 512'(5));
    chk("stall_wb_way", 512'(wb_way), 512'(2));

    // Same refill while draining: buffer reloads with old (7,1)
    rd_en    = 1'b0;
    wb_ready = 1'b1;
    #1;
    chk("drain_refill_ready", 512'(refill_ready), 512'(1));
    tick(0);
    idle();
    chk("reload_wb_valid", 512'(wb_valid), 512'(1));
    chk("reload_wb_data", wb_data, mdl[7*4+1]);
    chk("reload_wb_index", 512'(wb_index), 512'(7));
    chk("reload_wb_way", 512'(wb_way), 512'(1));
    mdl[7*4+1] = mk(8'hD0);
    tick(0);
    chk("drained_wb_valid", 512'(wb_valid), 512'(0));
    do_read(7, 1);

    // Refill + update + read in one cycle: only the refill lands
    set_addr(3, 0);
    refill      = 1'b1;
    refill_data = mk(8'hE0);
    update      = 1'b1;
    wr_data     = {64{8'h11}};
    wr_be       = '1;
    rd_en       = 1'b1;
    mdl[3*4+0]  = mk(8'hE0);
    tick(0);
    idle();
    do_read(3, 0);

    // Empty byte mask, then a scattered mask
    do_update(3, 0, {64{8'h22}}, '0);
    do_read(3, 0);
    do_update(3, 0, {8{64'h0123_4567_89AB_CDEF}}, 64'h8000_0000_F000_0101);
    do_read(3, 0);

    // Reset while a victim is pending discards it and blocks the refill
    wb_ready = 1'b0;
    set_addr(3, 0);
    refill      = 1'b1;
    evict       = 1'b1;
    refill_data = mk(8'h60);
    mdl[3*4+0]  = mk(8'h60);
    tick(0);
    idle();
    chk("pend_wb_valid", 512'(wb_valid), 512'(1));
    rst         = 1'b1;
    refill      = 1'b1;
    refill_data = mk(8'h70);
    rd_en       = 1'b1;
    tick(0);
    rst = 1'b0;
    idle();
    chk("rst_pend_wb_valid", 512'(wb_valid), 512'(0));
    chk("rst_pend_wb_data", wb_data, '0);
    chk("rst_pend_rd_data", rd_data, '0);
    do_read(3, 0);

`ifdef L2_DATA_PARITY_EN
    do_refill(9, 3, mk(8'hC5));
    dut.mem[9*4+3][0] = ~dut.mem[9*4+3][0];
    mdl[9*4+3][0]     = ~mdl[9*4+3][0];
    set_addr(9, 3);
    rd_en = 1'b1;
    exp_q.push_back('{data: mdl[9*4+3], perr: 1'b1});
    tick(1);
    idle();
`else
    do_refill(9, 3, mk(8'hC5));
    do_read(9, 3);
`endif

    tick(0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l2_data_array_wb.md
Name: l2_data_array_wb

Overview:
Parametrised successor to the L2 data array. It is a set-associative line store addressed by {index, way}, with registered reads, byte-enabled write-hit updates and memory refills. It also has a one-entry victim writeback buffer with a valid/ready handshake toward memory. It sits between the L2 controller (tag/FSM side) and the memory interface.

Parameters:
NUM_SETS, 32, number of sets; power of two, at least 2.
NUM_WAYS, 4, associativity; power of two, at least 1.
LINE_BITS, 512, line width in bits; multiple of 64.
IDX_W, $clog2(NUM_SETS), derived; do not override.
WAY_W, max(1,$clog2(NUM_WAYS)), derived; do not override.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
index  in  IDX_W  set index.
way  in  WAY_W  way select.
rd_en  in  1  read request.
update  in  1  write-hit update from L1.
wr_data  in  LINE_BITS  update data.
wr_be  in  LINE_BITS/8  update byte enables; bit i covers byte i.
refill  in  1  line refill from memory.
refill_data  in  LINE_BITS  refill line.
evict  in  1  with refill: current line is dirty and must be written back.
refill_ready  out  1  refill with evict=1 can be accepted this cycle.
rd_data  out  LINE_BITS  read line.
rd_valid  out  1  rd_data valid; one-cycle pulse.
rd_perr  out  1  parity error on the read; see Optional Feature.
wb_valid  out  1  victim buffer holds a line.
wb_ready  in  1  memory accepts the victim.
wb_data  out  LINE_BITS  victim line.
wb_index  out  IDX_W  victim set.
wb_way  out  WAY_W  victim way.

Behaviour:
- Storage: NUM_SETS*NUM_WAYS lines at address {index, way}. Array contents are not reset.
- Single-ported, one operation per cycle. Priority: accepted refill > update > rd_en. Lower-priority requests in the same cycle are ignored: no write, no rd_valid.
- Refill accept:
  - evict=0: always accepted.
  - evict=1: accepted only if refill_ready=1.
  - A refill with evict=1 and refill_ready=0 is ignored entirely: line unchanged. Update/read in that cycle proceed per priority, as though no refill were present.
- Accepted refill: the line is overwritten with refill_data at the clock edge.
- Accepted refill with evict=1: the pre-write line plus index/way load into the victim buffer on the same edge. wb_valid=1 from the next cycle.
- refill_ready = !wb_valid | wb_ready (combinational).
- Victim handshake:
  - Transfer occurs when wb_valid & wb_ready.
  - wb_data/wb_index/wb_way are held stable while wb_valid=1 and wb_ready=0.
  - Drain and a new evict in the same cycle: the buffer reloads and wb_valid stays 1.
- Update: bytes with wr_be[i]=1 are written; other bytes are unchanged. wr_be all-zero means no change.
- Read: latency 1. rd_data is the line as of the request edge. rd_valid pulses the next cycle. rd_data holds its last value when rd_valid=0.
- Reset (synchronous): rd_valid=0, rd_data=0, rd_perr=0, wb_valid=0, wb_data=0, wb_index=0, wb_way=0. Reset during a pending victim discards it with no handshake. rst has priority over all requests that cycle.

Optional Feature:
Macro L2_DATA_PARITY_EN.
- Defined:
  - One even-parity bit per 64-bit word is stored per line. Parity is computed on refill and on the merged update result.
  - rd_perr pulses with rd_valid if any word mismatches.
  - The victim line carries no parity check.
- Undefined: no parity storage; rd_perr is tied to 0.

Decomposition:
- Package l2_cache_pkg: default NUM_SETS/NUM_WAYS/LINE_BITS constants, line_t (logic [LINE_BITS-1:0]), be_t, and a helper for the {index, way} address.
- Sub-module l2_wb_buffer: one-entry valid/ready register slice holding data/index/way. It exports ready-for-load (!valid | ready).

Test Plan:
- Reset, then refill (5,2) with pattern A, evict=0; rd_en (5,2) -> next cycle rd_valid=1, rd_data=A, wb_valid stays 0.
- Update (5,2), wr_data all 0xFF bytes, wr_be=0x1 -> read returns A with byte 0=0xFF, all other bytes unchanged.
- Refill (5,2) with B, evict=1 -> next cycle wb_valid=1, wb_data=modified A, wb_index=5, wb_way=2; read (5,2)=B.
- Hold wb_ready=0; refill (7,1) evict=1 -> refill_ready=0, line (7,1) unchanged, wb_* stable. Then wb_ready=1 with the same refill -> accepted; buffer now holds old (7,1).
- Refill, update and rd_en to (3,0) in the same cycle -> only the refill lands; no rd_valid next cycle.
- With L2_DATA_PARITY_EN: refill C, force one stored data bit flip, read -> rd_perr=1 with rd_valid. Without the macro, rd_perr stays 0.
